mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multicycle control FSM for the MIPS datapath built around the shared 3-bit-op ALU. It sequences one instruction at a time through fetch, decode, execute, memory and write-back states. Every cycle it drives the ALU opcode, the operand-mux selects and all architectural write enables. It sits between the IR/ALU-zero flag and the PC, IR, register-file and data-memory write ports.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- instr  input  32  IR contents; stable from DECODE until the next FETCH
- zero  input  1  ALU equality flag (inA == inB)
- pc_we, ir_we, rf_we, mem_we  output  1 each  write enables
- alu_op  output  3  ADDU 000, SUBU 001, AND 010, OR 011, LUI 100
- alu_src_a  output  1  0 = PC, 1 = rs data
- alu_src_b  output  2  0 = rt data, 1 = const 4, 2 = ext imm, 3 = sign-ext imm << 2
- ext_op  output  1  0 = zero-extend, 1 = sign-extend
- aluout_we  output  1  latch the ALU result into ALUOut
- reg_dst  output  2  0 = rt, 1 = rd, 2 = $31
- mem_to_reg  output  2  0 = ALUOut, 1 = MDR, 2 = PC
- pc_src  output  2  0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], instr[25:0], 2'b00}, 3 = rs data
- retire  output  1  one-cycle pulse in the last state of each instruction
- illegal  output  1  sticky; set on an unknown encoding
- state  output  4  current state, for debug

## Operation
- Supported: addu, subu, and, or (R-type, funct 0x21/0x23/0x24/0x25), ori, lui, lw, sw, beq, j, jal, jr (funct 0x08).
- States: FETCH 0, DECODE 1, EXE_R 2, EXE_I 3, MEMADR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10, ILLEGAL 11.
- FETCH:
  - ir_we=1, pc_we=1, pc_src=0, alu_src_a=0, alu_src_b=1, alu_op=ADDU.
  - Next state is DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=3, alu_op=ADDU, aluout_we=1, so ALUOut holds the branch target.
  - Next state by class: R-ALU→EXE_R; ori/lui→EXE_I; lw/sw→MEMADR; beq→BRANCH; j/jal/jr→JUMP; else→ILLEGAL.
- EXE_R: alu_src_a=1, alu_src_b=0, alu_op from funct, aluout_we=1. Next state WB_ALU with reg_dst=1.
- EXE_I: alu_src_a=1, alu_src_b=2, ext_op=0, alu_op=OR (ori) or LUI, aluout_we=1. Next state WB_ALU with reg_dst=0.
- MEMADR: alu_src_a=1, alu_src_b=2, ext_op=1, ADDU, aluout_we=1. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD → WB_MEM. WB_MEM: rf_we=1, reg_dst=0, mem_to_reg=1.
- MEM_WR: mem_we=1, retire=1.
- WB_ALU: rf_we=1, mem_to_reg=0, retire=1.
- BRANCH: alu_src_a=1, alu_src_b=0, SUBU, pc_src=1, pc_we=zero, retire=1.
- JUMP:
  - pc_we=1, retire=1.
  - pc_src=2 for j/jal, 3 for jr.
  - jal also drives rf_we=1, reg_dst=2, mem_to_reg=2. The PC already holds PC+4, so $31 receives PC+4.
- After every retire state, the next state is FETCH.
- ILLEGAL:
  - illegal=1 and the state holds.
  - All enables stay 0 until reset.
- Every output not listed for a state is 0.

## Timing
- Outputs are combinational from the registered state and instr. All writes take effect on the clk edge that ends the state.
- Latency in cycles: R-type, ori and lui 4; lw 5; sw 4; beq, j, jal and jr 3.
- Reset:
  - reset=0 at an edge sets state=FETCH and illegal=0.
  - While reset=0, all write enables and retire are forced to 0. Every other output is 0.
- Reset asserted mid-instruction abandons the instruction: no partial write occurs after the reset edge.
- The first FETCH follows the first edge at which reset=1.

## Configuration
- MC_CTRL_JUMP_EN defined: j, jal and jr are decoded as described above.
- MC_CTRL_JUMP_EN undefined:
  - The JUMP state and pc_src values 2/3 are never produced.
  - j, jal and jr decode to ILLEGAL.

## Structure
- Package mc_pkg holds:
  - opcode and funct constants;
  - the ALU op codes;
  - the state encoding;
  - the reg_dst, mem_to_reg, pc_src and alu_src_b select encodings.
- One sub-module, mc_decode, is a combinational classifier: instr → {is_r_alu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, is_bad}.

## Test plan
- Reset, then addu 0x00221821:
  - States run 0→1→2→7.
  - In state 7: rf_we=1, reg_dst=1, retire=1.
  - The next state is FETCH.
- lw 0x8C220004: 5 cycles; state 5 then state 8 with rf_we=1 and mem_to_reg=1; mem_we never asserts.
- beq 0x10220003:
  - With zero=1: pc_we=1 and pc_src=1 in BRANCH.
  - With zero=0: pc_we=0.
  - Both cases take 3 cycles.
- jal 0x0C000010: in JUMP, pc_src=2, rf_we=1, reg_dst=2, mem_to_reg=2. With MC_CTRL_JUMP_EN undefined, the same word sets illegal=1.
- 0xFC000000: state→11; illegal stays 1 with all enables 0 for 10 cycles; reset clears it.
- reset=0 during MEM_RD of a lw: the next state is FETCH, and rf_we is never asserted for that lw.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU ops,
// FSM states, datapath mux selects and the instruction-class record.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;

    typedef enum logic [2:0] {
        ALU_ADDU = 3'd0,
        ALU_SUBU = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_LUI  = 3'd4
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_MEMADR  = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ILLEGAL = 4'd11
    } state_e;

    localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
    localparam logic [1:0] M2R_ALUOUT = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2;
    localparam logic [1:0] PCS_ALU = 2'd0, PCS_ALUOUT = 2'd1, PCS_JTGT = 2'd2, PCS_RS = 2'd3;
    localparam logic [1:0] SRCB_RT = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_BOFF = 2'd3;

    typedef struct packed {
        logic is_r_alu;
        logic is_ori;
        logic is_lui;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_j;
        logic is_jal;
        logic is_jr;
        logic is_bad;
    } instr_class_t;

    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUBU: return ALU_SUBU;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            default: return ALU_ADDU;
        endcase
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier. With MC_CTRL_JUMP_EN undefined the
// jump flags stay low and j/jal/jr are reported as bad encodings.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls
);

`ifdef MC_CTRL_JUMP_EN
    localparam logic JUMP_EN = 1'b1;
`else
    localparam logic JUMP_EN = 1'b0;
`endif

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR: cls.is_r_alu = 1'b1;
                    FN_JR:                           cls.is_jr    = JUMP_EN;
                    default:                         ;
                endcase
            end
            OP_ORI:  cls.is_ori = 1'b1;
            OP_LUI:  cls.is_lui = 1'b1;
            OP_LW:   cls.is_lw  = 1'b1;
            OP_SW:   cls.is_sw  = 1'b1;
            OP_BEQ:  cls.is_beq = 1'b1;
            OP_J:    cls.is_j   = JUMP_EN;
            OP_JAL:  cls.is_jal = JUMP_EN;
            default: ;
        endcase
        cls.is_bad = ~(cls.is_r_alu | cls.is_ori | cls.is_lui | cls.is_lw | cls.is_sw |
                       cls.is_beq | cls.is_j | cls.is_jal | cls.is_jr);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS datapath. Define MC_CTRL_JUMP_EN to
// enable the j/jal/jr JUMP state; otherwise those encodings go to ILLEGAL.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        mem_we,
    output logic [2:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_op,
    output logic        aluout_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  pc_src,
    output logic        retire,
    output logic        illegal,
    output logic [3:0]  state
);

    state_e       state_q, state_d;
    logic         run_q;
    instr_class_t cls;

    mc_decode u_decode (
        .instr (instr),
        .cls   (cls)
    );

`ifndef MC_CTRL_JUMP_EN
    logic unused_jump;
    assign unused_jump = cls.is_j ^ cls.is_jal ^ cls.is_jr;
`endif

    // run_q holds the FSM in FETCH for the edge that first samples reset high
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    if (cls.is_bad)                  state_d = S_ILLEGAL;
                    else if (cls.is_r_alu)           state_d = S_EXE_R;
                    else if (cls.is_ori | cls.is_lui) state_d = S_EXE_I;
                    else if (cls.is_lw | cls.is_sw)  state_d = S_MEMADR;
                    else if (cls.is_beq)             state_d = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
                    else if (cls.is_j | cls.is_jal | cls.is_jr) state_d = S_JUMP;
`endif
                    else                             state_d = S_ILLEGAL;
                end
                S_EXE_R, S_EXE_I: state_d = S_WB_ALU;
                S_MEMADR:         state_d = cls.is_lw ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:         state_d = S_WB_MEM;
                S_ILLEGAL:        state_d = S_ILLEGAL;
                default:          state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        mem_we     = 1'b0;
        alu_op     = ALU_ADDU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        ext_op     = 1'b0;
        aluout_we  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALUOUT;
        pc_src     = PCS_ALU;
        retire     = 1'b0;
        illegal    = 1'b0;
        state      = 4'd0;
        if (reset && run_q) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    alu_src_b = SRCB_FOUR;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_BOFF;
                    aluout_we = 1'b1;
                end
                S_EXE_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = funct_to_alu(instr[5:0]);
                    aluout_we = 1'b1;
                end
                S_EXE_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = cls.is_lui ? ALU_LUI : ALU_OR;
                    aluout_we = 1'b1;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    ext_op    = 1'b1;
                    aluout_we = 1'b1;
                end
                S_MEM_WR: begin
                    mem_we = 1'b1;
                    retire = 1'b1;
                end
                S_WB_ALU: begin
                    rf_we   = 1'b1;
                    reg_dst = cls.is_r_alu ? RD_RD : RD_RT;
                    retire  = 1'b1;
                end
                S_WB_MEM: begin
                    rf_we      = 1'b1;
                    mem_to_reg = M2R_MDR;
                    retire     = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUBU;
                    pc_src    = PCS_ALUOUT;
                    pc_we     = zero;
                    retire    = 1'b1;
                end
`ifdef MC_CTRL_JUMP_EN
                S_JUMP: begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    pc_src = cls.is_jr ? PCS_RS : PCS_JTGT;
                    if (cls.is_jal) begin
                        rf_we      = 1'b1;
                        reg_dst    = RD_RA;
                        mem_to_reg = M2R_PC;
                    end
                end
`endif
                S_ILLEGAL: illegal = 1'b1;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random instruction
// streams, compared every cycle against a behavioural path/output model.
module tb_mc_ctrl;

`ifdef MC_CTRL_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        pc_we, ir_we, rf_we, mem_we;
    logic [2:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ext_op, aluout_we;
    logic [1:0]  reg_dst, mem_to_reg, pc_src;
    logic        retire, illegal;
    logic [3:0]  state;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .mem_we(mem_we),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_op(ext_op), .aluout_we(aluout_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .pc_src(pc_src), .retire(retire),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_we, ir_we, rf_we, mem_we;
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op, aluout_we;
        logic [1:0] reg_dst, mem_to_reg, pc_src;
        logic       retire, illegal;
        logic [3:0] state;
    } out_t;

    typedef int iq_t[$];

    localparam int C_R = 0, C_ORI = 1, C_LUI = 2, C_LW = 3, C_SW = 4, C_BEQ = 5,
                   C_J = 6, C_JAL = 7, C_JR = 8, C_BAD = 9;

    out_t dut_o;
    assign dut_o = {pc_we, ir_we, rf_we, mem_we, alu_op, alu_src_a, alu_src_b, ext_op,
                    aluout_we, reg_dst, mem_to_reg, pc_src, retire, illegal, state};

    int   n_vec = 0;
    int   n_err = 0;
    int   obs_state[$];
    out_t obs_out[$];

    function automatic int cls_of(input logic [31:0] w);
        case (w[31:26])
            6'h00: begin
                if (w[5:0] == 6'h21 || w[5:0] == 6'h23 || w[5:0] == 6'h24 || w[5:0] == 6'h25)
                    return C_R;
                if (w[5:0] == 6'h08) return JEN ? C_JR : C_BAD;
                return C_BAD;
            end
            6'h0D:   return C_ORI;
            6'h0F:   return C_LUI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h02:   return JEN ? C_J : C_BAD;
            6'h03:   return JEN ? C_JAL : C_BAD;
            default: return C_BAD;
        endcase
    endfunction

    // State visited in each cycle of one instruction
    function automatic iq_t path_of(input int c);
        case (c)
            C_R:          return '{0, 1, 2, 7};
            C_ORI, C_LUI: return '{0, 1, 3, 7};
            C_LW:         return '{0, 1, 4, 5, 8};
            C_SW:         return '{0, 1, 4, 6};
            C_BEQ:        return '{0, 1, 9};
            C_J, C_JAL, C_JR: return '{0, 1, 10};
            default:      return '{0, 1, 11};
        endcase
    endfunction

    function automatic out_t model(input int st, input logic [31:0] w, input logic z);
        out_t o;
        int   c;
        o = '0;
        c = cls_of(w);
        o.state = 4'(st);
        case (st)
            0: begin o.ir_we = 1; o.pc_we = 1; o.alu_src_b = 2'd1; end
            1: begin o.alu_src_b = 2'd3; o.aluout_we = 1; end
            2: begin
                o.alu_src_a = 1; o.aluout_we = 1;
                case (w[5:0])
                    6'h23:   o.alu_op = 3'd1;
                    6'h24:   o.alu_op = 3'd2;
                    6'h25:   o.alu_op = 3'd3;
                    default: o.alu_op = 3'd0;
                endcase
            end
            3: begin
                o.alu_src_a = 1; o.alu_src_b = 2'd2; o.aluout_we = 1;
                o.alu_op = (c == C_LUI) ? 3'd4 : 3'd3;
            end
            4: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.ext_op = 1; o.aluout_we = 1; end
            6: begin o.mem_we = 1; o.retire = 1; end
            7: begin o.rf_we = 1; o.retire = 1; o.reg_dst = (c == C_R) ? 2'd1 : 2'd0; end
            8: begin o.rf_we = 1; o.retire = 1; o.mem_to_reg = 2'd1; end
            9: begin
                o.alu_src_a = 1; o.alu_op = 3'd1; o.pc_src = 2'd1; o.pc_we = z; o.retire = 1;
            end
            10: begin
                o.pc_we = 1; o.retire = 1;
                o.pc_src = (c == C_JR) ? 2'd3 : 2'd2;
                if (c == C_JAL) begin o.rf_we = 1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd2; end
            end
            11: o.illegal = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic step(input out_t exp, input string tag);
        @(negedge clk);
        n_vec++;
        obs_state.push_back(int'(dut_o.state));
        obs_out.push_back(dut_o);
        if (dut_o !== exp) begin
            n_err++;
            $display("FAIL %s instr=%h: got outputs %h, expected %h", tag, instr, dut_o, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step('0, "reset_hold");
        step('0, "reset_hold");
        reset = 1'b1;
        step('0, "reset_release");
    endtask

    // zmode < 0 randomizes zero each cycle; abort_idx >= 0 drops reset in that cycle
    task automatic run_instr(input logic [31:0] w, input int zmode, input int abort_idx,
                             output bit went_bad);
        iq_t  p;
        logic zv;
        p = path_of(cls_of(w));
        went_bad = (cls_of(w) == C_BAD);
        instr = w;
        obs_state.delete();
        obs_out.delete();
        for (int i = 0; i < p.size(); i++) begin
            if (i == abort_idx) begin
                do_reset();
                went_bad = 1'b0;
                return;
            end
            zv = (zmode < 0) ? logic'($urandom_range(0, 1)) : logic'(zmode);
            zero = zv;
            step(model(p[i], w, zv), "cycle");
        end
        if (went_bad) begin
            for (int k = 0; k < 10; k++) begin
                zero = logic'($urandom_range(0, 1));
                step(model(11, w, zero), "illegal_hold");
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  fn;
        r = $urandom;
        case ($urandom_range(0, 10))
            0: begin
                case ($urandom_range(0, 3))
                    0: fn = 6'h21;
                    1: fn = 6'h23;
                    2: fn = 6'h24;
                    default: fn = 6'h25;
                endcase
                return {6'h00, r[25:6], fn};
            end
            1:  return {6'h0D, r[25:0]};
            2:  return {6'h0F, r[25:0]};
            3:  return {6'h23, r[25:0]};
            4:  return {6'h2B, r[25:0]};
            5:  return {6'h04, r[25:0]};
            6:  return {6'h02, r[25:0]};
            7:  return {6'h03, r[25:0]};
            8:  return {6'h00, r[25:6], 6'h08};
            9:  return {6'h00, r[25:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        bit   bad;
        int   rf_seen;
        logic [31:0] w;
        reset = 1'b0;
        instr = 32'h0;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        check_lit("reset_state", obs_state[obs_state.size()-1], 0);

        run_instr(32'h00221821, -1, -1, bad);
        check_lit("addu_len", obs_state.size(), 4);
        check_lit("addu_s2", obs_state[2], 2);
        check_lit("addu_s3", obs_state[3], 7);
        check_lit("addu_rf_we", int'(obs_out[3].rf_we), 1);
        check_lit("addu_reg_dst", int'(obs_out[3].reg_dst), 1);
        check_lit("addu_retire", int'(obs_out[3].retire), 1);

        run_instr(32'h8C220004, -1, -1, bad);
        check_lit("lw_len", obs_state.size(), 5);
        check_lit("lw_s3", obs_state[3], 5);
        check_lit("lw_s4", obs_state[4], 8);
        check_lit("lw_m2r", int'(obs_out[4].mem_to_reg), 1);
        rf_seen = 0;
        foreach (obs_out[i]) rf_seen += int'(obs_out[i].mem_we);
        check_lit("lw_no_mem_we", rf_seen, 0);

        run_instr(32'h10220003, 1, -1, bad);
        check_lit("beq_z1_len", obs_state.size(), 3);
        check_lit("beq_z1_pc_we", int'(obs_out[2].pc_we), 1);
        check_lit("beq_z1_pc_src", int'(obs_out[2].pc_src), 1);
        run_instr(32'h10220003, 0, -1, bad);
        check_lit("beq_z0_pc_we", int'(obs_out[2].pc_we), 0);

        run_instr(32'h0C000010, -1, -1, bad);
        if (JEN) begin
            check_lit("jal_pc_src", int'(obs_out[2].pc_src), 2);
            check_lit("jal_reg_dst", int'(obs_out[2].reg_dst), 2);
            check_lit("jal_m2r", int'(obs_out[2].mem_to_reg), 2);
        end else begin
            check_lit("jal_illegal", int'(obs_out[2].illegal), 1);
        end
        if (bad) do_reset();

        run_instr(32'hFC000000, -1, -1, bad);
        check_lit("bad_state", obs_state[2], 11);
        check_lit("bad_sticky", int'(obs_out[obs_out.size()-1].illegal), 1);
        do_reset();
        check_lit("bad_cleared", int'(obs_out[obs_out.size()-1].illegal), 0);

        run_instr(32'h8C220004, -1, 3, bad);
        check_lit("abort_s2", obs_state[2], 4);
        rf_seen = 0;
        foreach (obs_out[i]) rf_seen += int'(obs_out[i].rf_we);
        check_lit("abort_no_rf_we", rf_seen, 0);
        run_instr(32'h00221821, -1, -1, bad);
        check_lit("restart_s0", obs_state[0], 0);

        for (int n = 0; n < 300; n++) begin
            w = rand_instr();
            run_instr(w, -1, -1, bad);
            if (bad) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
